// File: rtl/c3lib_ckmux_seq_pkg.sv
// Shared types and helpers for the sequenced N:1 clock mux.
// Holds the control FSM state encoding, the one-hot helper and the counter sizing rule.
package c3lib_ckmux_seq_pkg;

  // Widest mux the one-hot helper supports; callers size-cast down to NUM_CK.
  localparam int unsigned ONEHOT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_OFF = 2'd1,
    ST_ON  = 2'd2
  } ckmux_state_e;

  // One-hot of idx within a field of the given width; all-zero when idx is out of range.
  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                     input int unsigned width);
    logic [ONEHOT_MAX_W-1:0] v;
    v = '0;
    if (idx < width && idx < ONEHOT_MAX_W) begin
      v = ONEHOT_MAX_W'(1) << idx;
    end
    return v;
  endfunction

  // Counter width able to hold the longer of the drain and settle intervals.
  function automatic int unsigned cnt_width(input int unsigned drain_cyc,
                                            input int unsigned settle_cyc);
    int unsigned m;
    m = (drain_cyc > settle_cyc) ? drain_cyc : settle_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/c3lib_ckmux_seq_ckg.sv
// Latch-based clock gate: the enable is captured while ck is low so the gated
// clock can only start or stop on a full low phase, never mid-pulse.
module c3lib_ckmux_seq_ckg (
  input  logic ck,
  input  logic en,
  output logic gck
);

  logic en_lat;

  always_latch begin
    if (!ck) begin
      en_lat <= en;
    end
  end

  assign gck = ck & en_lat;

endmodule

// File: rtl/c3lib_ckmux_seq_ctl.sv
// Switch sequencer on clk: accepts select requests, drains with all gates off,
// enables the new input, waits for it to settle, then acknowledges.
module c3lib_ckmux_seq_ctl
  import c3lib_ckmux_seq_pkg::*;
#(
  parameter int unsigned NUM_CK     = 4,
  parameter int unsigned SEL_W      = $clog2(NUM_CK),
  parameter int unsigned DRAIN_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_req,
  output logic              sel_ack,
  output logic              busy,
  output logic              req_err,
  output logic [SEL_W-1:0]  cur_sel,
  output logic [NUM_CK-1:0] ck_en
);

  localparam int unsigned CNT_W = cnt_width(DRAIN_CYC, SETTLE_CYC);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  ckmux_state_e      state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SEL_W-1:0]  target_reg, target_next;
  logic [SEL_W-1:0]  cur_sel_reg, cur_sel_next;
  logic [NUM_CK-1:0] ck_en_reg, ck_en_next;
  logic              busy_reg, busy_next;
  logic              sel_ack_reg, sel_ack_next;
  logic              req_err_reg, req_err_next;
  // Set only by a real switch, so the reset bring-up finishes without an ack.
  logic              switch_reg, switch_next;

  logic              sel_ok;
  logic [NUM_CK-1:0] cur_oh;
  logic [NUM_CK-1:0] target_oh;

  assign sel_ok    = (32'(sel) < NUM_CK);
  assign cur_oh    = NUM_CK'(onehot(32'(cur_sel_reg), NUM_CK));
  assign target_oh = NUM_CK'(onehot(32'(target_reg), NUM_CK));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_ON;
      cnt_reg     <= '0;
      target_reg  <= '0;
      cur_sel_reg <= '0;
      ck_en_reg   <= '0;
      busy_reg    <= 1'b1;
      sel_ack_reg <= 1'b0;
      req_err_reg <= 1'b0;
      switch_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      target_reg  <= target_next;
      cur_sel_reg <= cur_sel_next;
      ck_en_reg   <= ck_en_next;
      busy_reg    <= busy_next;
      sel_ack_reg <= sel_ack_next;
      req_err_reg <= req_err_next;
      switch_reg  <= switch_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    target_next  = target_reg;
    cur_sel_next = cur_sel_reg;
    ck_en_next   = ck_en_reg;
    busy_next    = busy_reg;
    switch_next  = switch_reg;
    sel_ack_next = 1'b0;
    req_err_next = 1'b0;

    if (freeze) begin
      // Scan override holds every register, pulses included, until release.
      sel_ack_next = sel_ack_reg;
      req_err_next = req_err_reg;
    end else begin
      case (state_reg)
        ST_RUN: begin
          busy_next  = 1'b0;
          ck_en_next = cur_oh;
          if (sel_req) begin
            if (!sel_ok) begin
              req_err_next = 1'b1;
            end else if (sel == cur_sel_reg) begin
              sel_ack_next = 1'b1;
            end else begin
              target_next = sel;
              state_next  = ST_OFF;
              cnt_next    = '0;
              ck_en_next  = '0;
              busy_next   = 1'b1;
              switch_next = 1'b1;
            end
          end
        end

        ST_OFF: begin
          busy_next    = 1'b1;
          ck_en_next   = '0;
          req_err_next = sel_req;
          if (cnt_reg == DRAIN_LAST) begin
            state_next   = ST_ON;
            cnt_next     = '0;
            cur_sel_next = target_reg;
            ck_en_next   = target_oh;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        ST_ON: begin
          busy_next    = 1'b1;
          ck_en_next   = cur_oh;
          req_err_next = sel_req;
          if (cnt_reg == SETTLE_LAST) begin
            state_next   = ST_RUN;
            cnt_next     = '0;
            busy_next    = 1'b0;
            sel_ack_next = switch_reg;
            switch_next  = 1'b0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        default: begin
          state_next   = ST_ON;
          cnt_next     = '0;
          cur_sel_next = '0;
          ck_en_next   = '0;
          busy_next    = 1'b1;
          switch_next  = 1'b0;
        end
      endcase
    end
  end

  assign sel_ack = sel_ack_reg;
  assign busy    = busy_reg;
  assign req_err = req_err_reg;
  assign cur_sel = cur_sel_reg;
  assign ck_en   = ck_en_reg;

endmodule

// File: rtl/c3lib_ckmux_seq_ctn.sv
// Parametrised N:1 clock mux with break-before-make sequencing and a scan
// override that forces a static selection onto the gate enables.
module c3lib_ckmux_seq_ctn
  import c3lib_ckmux_seq_pkg::*;
#(
  parameter int unsigned NUM_CK     = 4,
  parameter int unsigned SEL_W      = $clog2(NUM_CK),
  parameter int unsigned DRAIN_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CK-1:0] ck_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_req,
  output logic              sel_ack,
  output logic              busy,
  output logic              req_err,
  output logic [SEL_W-1:0]  cur_sel,
  input  logic              tst_override,
  input  logic [SEL_W-1:0]  tst_sel,
  output logic [NUM_CK-1:0] ck_en,
  output logic              ck_out
);

  logic [NUM_CK-1:0] ctl_ck_en;
  logic [NUM_CK-1:0] scan_en;
  logic [NUM_CK-1:0] gck;

  c3lib_ckmux_seq_ctl #(
    .NUM_CK     (NUM_CK),
    .SEL_W      (SEL_W),
    .DRAIN_CYC  (DRAIN_CYC),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_ctl (
    .clk     (clk),
    .rst     (rst),
    .freeze  (tst_override),
    .sel     (sel),
    .sel_req (sel_req),
    .sel_ack (sel_ack),
    .busy    (busy),
    .req_err (req_err),
    .cur_sel (cur_sel),
    .ck_en   (ctl_ck_en)
  );

  // A tst_sel beyond NUM_CK matches no lane, leaving every gate closed.
  for (genvar gi = 0; gi < NUM_CK; gi++) begin : g_lane
    assign scan_en[gi] = (tst_sel == SEL_W'(gi));
    assign ck_en[gi]   = tst_override ? scan_en[gi] : ctl_ck_en[gi];

    c3lib_ckmux_seq_ckg u_ckg (
      .ck  (ck_in[gi]),
      .en  (ck_en[gi]),
      .gck (gck[gi])
    );
  end

  assign ck_out = |gck;

endmodule

// File: tb/tb_c3lib_ckmux_seq_ctn.sv
// Directed bench for the sequenced clock mux: bring-up, switch timing, no-op,
// range and busy rejection, scan override freeze, reset mid-switch, selection walk.
module tb_c3lib_ckmux_seq_ctn;

  logic       clk = 1'b0;
  logic       rst;
  logic       ck0 = 1'b0, ck1 = 1'b0, ck2 = 1'b0, ck3 = 1'b0;
  logic [3:0] ck_in;
  logic [1:0] sel;
  logic       sel_req;
  logic       sel_ack, busy, req_err;
  logic [1:0] cur_sel;
  logic       tst_override;
  logic [1:0] tst_sel;
  logic [3:0] ck_en;
  logic       ck_out;

  logic [2:0] ck_in3;
  logic [1:0] sel3, cur_sel3, tst_sel3;
  logic       sel_req3, sel_ack3, busy3, req_err3, tst_ovr3, ck_out3;
  logic [2:0] ck_en3;

  int checks = 0;
  int errors = 0;
  int glitch_cnt = 0;
  int multihot_cnt = 0;
  int gap_viol = 0;

  assign ck_in  = {ck3, ck2, ck1, ck0};
  assign ck_in3 = ck_in[2:0];

  always #5 clk = ~clk;
  initial forever #3 ck0 = ~ck0;
  initial forever #4 ck1 = ~ck1;
  initial forever #5 ck2 = ~ck2;
  initial forever #6 ck3 = ~ck3;

  c3lib_ckmux_seq_ctn #(.NUM_CK(4)) dut (
    .clk (clk), .rst (rst), .ck_in (ck_in), .sel (sel), .sel_req (sel_req),
    .sel_ack (sel_ack), .busy (busy), .req_err (req_err), .cur_sel (cur_sel),
    .tst_override (tst_override), .tst_sel (tst_sel), .ck_en (ck_en), .ck_out (ck_out)
  );

  c3lib_ckmux_seq_ctn #(.NUM_CK(3)) dut3 (
    .clk (clk), .rst (rst), .ck_in (ck_in3), .sel (sel3), .sel_req (sel_req3),
    .sel_ack (sel_ack3), .busy (busy3), .req_err (req_err3), .cur_sel (cur_sel3),
    .tst_override (tst_ovr3), .tst_sel (tst_sel3), .ck_en (ck_en3), .ck_out (ck_out3)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ck_out must track the selected input once its gate is open.
  task automatic ck_follow(input string tag, input int k);
    for (int i = 0; i < 2; i++) begin
      wait (ck_in[k] == 1'b0);
      wait (ck_in[k] == 1'b1);
      #1;
      chk({tag, "_hi"}, 32'(ck_out), 32'd1);
      wait (ck_in[k] == 1'b0);
      #1;
      chk({tag, "_lo"}, 32'(ck_out), 32'd0);
    end
  endtask

  // Full switch from RUN: 4 drain cycles, 4 settle cycles, ack on the 9th.
  task automatic do_switch(input logic [1:0] s, input string tag);
    logic [3:0] exp_oh;
    exp_oh = 4'b0001 << s;
    $display("txn %s sel=%0d", tag, s);
    sel = s;
    sel_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      sel_req = 1'b0;
      chk({tag, "_en"}, 32'(ck_en), (c <= 4) ? 32'd0 : 32'(exp_oh));
      chk({tag, "_busy"}, 32'(busy), (c <= 8) ? 32'd1 : 32'd0);
      chk({tag, "_ack"}, 32'(sel_ack), (c == 9) ? 32'd1 : 32'd0);
      if (c == 3) chk({tag, "_ckoff"}, 32'(ck_out), 32'd0);
    end
    chk({tag, "_cur"}, 32'(cur_sel), 32'(s));
  endtask

  // Enable monitor: never multi-hot, and >=4 zero cycles between different selections.
  logic [3:0] last_oh = '0;
  int zero_run = 0;
  always @(negedge clk) begin
    if (!$onehot0(ck_en)) multihot_cnt++;
    if (rst) begin
      last_oh = '0;
      zero_run = 0;
    end else if (!tst_override) begin
      if (ck_en == 4'd0) begin
        zero_run++;
      end else begin
        if (last_oh != 4'd0 && ck_en != last_oh && zero_run < 4) gap_viol++;
        last_oh = ck_en;
        zero_run = 0;
      end
    end
  end

  // Every ck_out phase must be at least the shortest input half-period.
  realtime last_t = 0.0;
  always @(ck_out) begin
    if (last_t > 0.0 && ($realtime - last_t) < 3.0) glitch_cnt++;
    last_t = $realtime;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sel = '0; sel_req = 1'b0; tst_override = 1'b0; tst_sel = '0;
    sel3 = '0; sel_req3 = 1'b0; tst_ovr3 = 1'b0; tst_sel3 = '0;
    repeat (3) tick();
    $display("txn reset");
    chk("rst_en", 32'(ck_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cur", 32'(cur_sel), 32'd0);
    chk("rst_ack", 32'(sel_ack), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);

    $display("txn bringup");
    rst = 1'b0;
    tick();
    chk("bu_en", 32'(ck_en), 32'd1);
    chk("bu_busy1", 32'(busy), 32'd1);
    tick();
    chk("bu_busy2", 32'(busy), 32'd1);
    tick();
    chk("bu_busy3", 32'(busy), 32'd1);
    chk("bu_ack3", 32'(sel_ack), 32'd0);
    tick();
    chk("bu_busy4", 32'(busy), 32'd0);
    chk("bu_ack4", 32'(sel_ack), 32'd0);
    chk("bu_cur", 32'(cur_sel), 32'd0);
    ck_follow("bu_ck", 0);

    tick();
    do_switch(2'd2, "sw2");
    ck_follow("sw2_ck", 2);

    $display("txn noop sel=2");
    tick();
    sel = 2'd2; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    chk("noop_ack", 32'(sel_ack), 32'd1);
    chk("noop_en", 32'(ck_en), 32'd4);
    chk("noop_busy", 32'(busy), 32'd0);
    tick();
    chk("noop_ack_clr", 32'(sel_ack), 32'd0);

    $display("txn range n3 sel=3");
    sel3 = 2'd3; sel_req3 = 1'b1;
    tick();
    sel_req3 = 1'b0;
    chk("rng_err", 32'(req_err3), 32'd1);
    chk("rng_en", 32'(ck_en3), 32'd1);
    chk("rng_busy", 32'(busy3), 32'd0);
    chk("rng_ack", 32'(sel_ack3), 32'd0);
    chk("rng_cur", 32'(cur_sel3), 32'd0);
    tick();
    chk("rng_err_clr", 32'(req_err3), 32'd0);
    wait (ck_in[0] == 1'b0);
    wait (ck_in[0] == 1'b1);
    #1;
    chk("rng_ck", 32'(ck_out3), 32'd1);

    $display("txn scan n3 tst_sel=3 then 2");
    tst_ovr3 = 1'b1; tst_sel3 = 2'd3;
    #1;
    chk("scan3_oor", 32'(ck_en3), 32'd0);
    tst_sel3 = 2'd2;
    #1;
    chk("scan3_sel2", 32'(ck_en3), 32'd4);
    tst_ovr3 = 1'b0;
    #1;
    chk("scan3_rel", 32'(ck_en3), 32'd1);

    $display("txn collision sel=3 then sel=1");
    tick();
    sel = 2'd3; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    tick();
    tick();
    sel = 2'd1; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    chk("col_err", 32'(req_err), 32'd1);
    chk("col_en", 32'(ck_en), 32'd0);
    chk("col_busy", 32'(busy), 32'd1);
    tick();
    chk("col_err_clr", 32'(req_err), 32'd0);
    chk("col_en_on", 32'(ck_en), 32'd8);
    repeat (3) tick();
    chk("col_ack_early", 32'(sel_ack), 32'd0);
    tick();
    chk("col_ack", 32'(sel_ack), 32'd1);
    chk("col_cur", 32'(cur_sel), 32'd3);
    chk("col_en_fin", 32'(ck_en), 32'd8);

    $display("txn scan override mid drain sel=1");
    tick();
    sel = 2'd1; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    tick();
    tst_override = 1'b1; tst_sel = 2'd1;
    #1;
    chk("scan_en", 32'(ck_en), 32'd2);
    sel = 2'd0; sel_req = 1'b1;
    repeat (2) begin
      tick();
      chk("scan_hold_en", 32'(ck_en), 32'd2);
      chk("scan_hold_busy", 32'(busy), 32'd1);
      chk("scan_no_err", 32'(req_err), 32'd0);
    end
    sel_req = 1'b0;
    tick();
    tst_override = 1'b0;
    #1;
    chk("scan_rel_en", 32'(ck_en), 32'd0);
    tick();
    chk("scan_drain2", 32'(ck_en), 32'd0);
    tick();
    chk("scan_drain3", 32'(ck_en), 32'd0);
    tick();
    chk("scan_on", 32'(ck_en), 32'd2);
    repeat (3) tick();
    chk("scan_busy", 32'(busy), 32'd1);
    chk("scan_ack_early", 32'(sel_ack), 32'd0);
    tick();
    chk("scan_ack", 32'(sel_ack), 32'd1);
    chk("scan_cur", 32'(cur_sel), 32'd1);

    $display("txn reset mid settle sel=3");
    tick();
    sel = 2'd3; sel_req = 1'b1;
    tick();
    sel_req = 1'b0;
    repeat (5) tick();
    chk("mid_on_en", 32'(ck_en), 32'd8);
    rst = 1'b1;
    tick();
    chk("mrst_en", 32'(ck_en), 32'd0);
    chk("mrst_cur", 32'(cur_sel), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    chk("mrst_bu_en", 32'(ck_en), 32'd1);
    chk("mrst_bu_ack1", 32'(sel_ack), 32'd0);
    tick();
    tick();
    chk("mrst_bu_busy", 32'(busy), 32'd1);
    tick();
    chk("mrst_bu_done", 32'(busy), 32'd0);
    chk("mrst_bu_ack", 32'(sel_ack), 32'd0);
    chk("mrst_bu_cur", 32'(cur_sel), 32'd0);
    tick();
    chk("mrst_bu_ack2", 32'(sel_ack), 32'd0);

    tick();
    do_switch(2'd1, "walk1");
    do_switch(2'd2, "walk2");
    do_switch(2'd3, "walk3");
    do_switch(2'd0, "walk0");
    ck_follow("walk0_ck", 0);

    chk("glitch_cnt", 32'(glitch_cnt), 32'd0);
    chk("multihot_cnt", 32'(multihot_cnt), 32'd0);
    chk("gap_viol", 32'(gap_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
